he_hssi_avmm_port_router: RTL and testbench



---
 rtl/he_hssi_avmm_port_router.sv | 135 +++++++++++++
 tb/tb_he_hssi_avmm_port_router.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/he_hssi_avmm_port_router.sv
// he_hssi_avmm_port_router: steers one upstream AVMM master to one of NUM_CH channel slaves.
// Define HE_HSSI_AVMM_TIMEOUT_EN to abort ISSUE after TIMEOUT_CYCLES stalled cycles.
module he_hssi_avmm_port_router #(
    parameter int NUM_CH         = 16,
    parameter int AVMM_ADDR_W    = 16,
    parameter int AVMM_DATA_W    = 32,
    parameter int SEL_W          = 6,
    parameter int WAIT_PIPE      = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          softreset,
    input  logic [AVMM_ADDR_W-1:0]        i_avmm_addr,
    input  logic                          i_avmm_read,
    input  logic                          i_avmm_write,
    input  logic [AVMM_DATA_W-1:0]        i_avmm_writedata,
    output logic [AVMM_DATA_W-1:0]        o_avmm_readdata,
    output logic                          o_avmm_waitrequest,
    input  logic [SEL_W-1:0]              i_port_sel,
    input  logic                          i_port_swap_en,
    output logic [AVMM_ADDR_W-1:0]        o_ch_addr,
    output logic [AVMM_DATA_W-1:0]        o_ch_writedata,
    output logic [NUM_CH-1:0]             o_ch_read,
    output logic [NUM_CH-1:0]             o_ch_write,
    input  logic [NUM_CH*AVMM_DATA_W-1:0] i_ch_readdata,
    input  logic [NUM_CH-1:0]             i_ch_waitrequest,
    input  logic                          i_err_clr,
    output logic                          o_err_badport,
    output logic                          o_err_timeout,
    output logic                          o_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, PIPE, RESP} state_t;
    state_t                 state_q, state_d, post_issue;
    logic [AVMM_ADDR_W-1:0] addr_q;
    logic [AVMM_DATA_W-1:0] wdata_q, cap_q, cap_d, rdata_q, ch_rdata;
    logic [SEL_W-1:0]       tgt, tgt_q;
    logic [NUM_CH-1:0]      sel_oh;
    logic [3:0]             pipe_q;
    logic                   wr_q, req, bad, ch_wait, accept, abort, pipe_done, err_bad_q;

    assign req        = i_avmm_read | i_avmm_write;
    assign tgt        = i_port_sel ^ {{(SEL_W-1){1'b0}}, i_port_swap_en};
    assign bad        = {1'b0, tgt} >= (SEL_W+1)'(NUM_CH);
    assign sel_oh     = NUM_CH'(1) << tgt_q;
    assign ch_wait    = |(i_ch_waitrequest & sel_oh);
    assign accept     = (state_q == ISSUE) && !ch_wait;
    assign pipe_done  = pipe_q == 4'(WAIT_PIPE - 1);
    assign post_issue = (WAIT_PIPE == 0) ? RESP : PIPE;

    // Select the read data of the latched target channel
    always_comb begin
        ch_rdata = '0;
        for (int n = 0; n < NUM_CH; n++)
            ch_rdata = ch_rdata | ({AVMM_DATA_W{sel_oh[n]}} & i_ch_readdata[n*AVMM_DATA_W +: AVMM_DATA_W]);
    end

`ifdef HE_HSSI_AVMM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_q;
    logic            err_to_q;
    assign abort         = (state_q == ISSUE) && ch_wait && (to_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign o_err_timeout = err_to_q;
    // Stall counter is zero outside ISSUE so it restarts on every entry; timeout flag is sticky
    always_ff @(posedge clk or posedge softreset) begin
        if (softreset) begin
            to_q     <= '0;
            err_to_q <= 1'b0;
        end else begin
            to_q     <= (state_q == ISSUE) ? to_q + 1'b1 : '0;
            err_to_q <= abort ? 1'b1 : (i_err_clr ? 1'b0 : err_to_q);
        end
    end
`else
    assign abort         = 1'b0;
    assign o_err_timeout = 1'b0;
`endif

    // Captured response: all-ones on bad port or abort, channel data on an accepted read
    always_comb cap_d = ((state_q == IDLE && req && bad) || abort) ? '1 :
                        (accept && !wr_q) ? ch_rdata : cap_q;

    // State register
    always_ff @(posedge clk or posedge softreset) begin
        if (softreset) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = bad ? post_issue : ISSUE;
            ISSUE:   if (accept || abort) state_d = post_issue;
            PIPE:    if (pipe_done) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, response capture, pipeline count and sticky bad-port flag
    always_ff @(posedge clk or posedge softreset) begin
        if (softreset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            tgt_q     <= '0;
            cap_q     <= '0;
            rdata_q   <= '0;
            pipe_q    <= '0;
            err_bad_q <= 1'b0;
        end else begin
            if (state_q == IDLE && req) begin
                addr_q  <= i_avmm_addr;
                wdata_q <= i_avmm_writedata;
                wr_q    <= i_avmm_write;
                tgt_q   <= tgt;
            end
            cap_q     <= cap_d;
            rdata_q   <= (state_d == RESP) ? cap_d : rdata_q;
            pipe_q    <= (state_q == PIPE) ? pipe_q + 4'd1 : 4'd0;
            err_bad_q <= (state_q == IDLE && req && bad) ? 1'b1 : (i_err_clr ? 1'b0 : err_bad_q);
        end
    end

    // Outputs decoded from the current state and latched request
    always_comb begin
        o_avmm_waitrequest = state_q != RESP;
        o_busy             = state_q != IDLE;
        o_ch_read          = (state_q == ISSUE && !wr_q) ? sel_oh : '0;
        o_ch_write         = (state_q == ISSUE && wr_q) ? sel_oh : '0;
        o_ch_addr          = addr_q;
        o_ch_writedata     = wdata_q;
        o_avmm_readdata    = rdata_q;
        o_err_badport      = err_bad_q;
    end
endmodule

// File: tb/tb_he_hssi_avmm_port_router.sv
// tb_he_hssi_avmm_port_router: directed vector bench for the AVMM port router (WAIT_PIPE=3 and WAIT_PIPE=0 builds).
module tb_he_hssi_avmm_port_router;
    localparam int NC = 16, AW = 16, DW = 32, SW = 6;

    logic clk = 1'b0, softreset = 1'b1;
    logic [AW-1:0] i_avmm_addr = '0;
    logic i_avmm_read = 1'b0, i_avmm_write = 1'b0, i_port_swap_en = 1'b0, i_err_clr = 1'b0;
    logic [DW-1:0] i_avmm_writedata = '0;
    logic [SW-1:0] i_port_sel = '0;
    logic [NC*DW-1:0] i_ch_readdata;
    logic [NC-1:0] i_ch_waitrequest = '0;
    logic [DW-1:0] o_avmm_readdata, o_ch_writedata, rdata0, chwd0;
    logic [AW-1:0] o_ch_addr, chaddr0;
    logic [NC-1:0] o_ch_read, o_ch_write, chrd0, chwr0;
    logic o_avmm_waitrequest, o_err_badport, o_err_timeout, o_busy, wait0, bad0, to0, busy0;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    he_hssi_avmm_port_router #(.NUM_CH(NC), .AVMM_ADDR_W(AW), .AVMM_DATA_W(DW), .SEL_W(SW),
        .WAIT_PIPE(3), .TIMEOUT_CYCLES(16)) u_dut (
        .clk(clk), .softreset(softreset), .i_avmm_addr(i_avmm_addr), .i_avmm_read(i_avmm_read),
        .i_avmm_write(i_avmm_write), .i_avmm_writedata(i_avmm_writedata), .o_avmm_readdata(o_avmm_readdata),
        .o_avmm_waitrequest(o_avmm_waitrequest), .i_port_sel(i_port_sel), .i_port_swap_en(i_port_swap_en),
        .o_ch_addr(o_ch_addr), .o_ch_writedata(o_ch_writedata), .o_ch_read(o_ch_read), .o_ch_write(o_ch_write),
        .i_ch_readdata(i_ch_readdata), .i_ch_waitrequest(i_ch_waitrequest), .i_err_clr(i_err_clr),
        .o_err_badport(o_err_badport), .o_err_timeout(o_err_timeout), .o_busy(o_busy));

    he_hssi_avmm_port_router #(.NUM_CH(NC), .AVMM_ADDR_W(AW), .AVMM_DATA_W(DW), .SEL_W(SW),
        .WAIT_PIPE(0), .TIMEOUT_CYCLES(16)) u_dut0 (
        .clk(clk), .softreset(softreset), .i_avmm_addr(i_avmm_addr), .i_avmm_read(i_avmm_read),
        .i_avmm_write(i_avmm_write), .i_avmm_writedata(i_avmm_writedata), .o_avmm_readdata(rdata0),
        .o_avmm_waitrequest(wait0), .i_port_sel(i_port_sel), .i_port_swap_en(i_port_swap_en),
        .o_ch_addr(chaddr0), .o_ch_writedata(chwd0), .o_ch_read(chrd0), .o_ch_write(chwr0),
        .i_ch_readdata(i_ch_readdata), .i_ch_waitrequest(i_ch_waitrequest), .i_err_clr(i_err_clr),
        .o_err_badport(bad0), .o_err_timeout(to0), .o_busy(busy0));

    typedef struct {
        logic rd, wr;
        logic [SW-1:0] sel;
        logic sw;
        int stall, ch;
        logic [DW-1:0] rdata;
        int resp;
        logic bad;
    } vec_t;
    vec_t v[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One upstream request sampled in cycle 0, then 60 cycles of observation
    task automatic run_txn(input logic rd, input logic wr, input logic [SW-1:0] sel, input logic sw,
                           input int stall, input int ch, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           output int rc, output int rc0, output int nstr, output int nbad, output int nlow,
                           output logic [DW-1:0] rdo, output logic [DW-1:0] rdo0);
        logic [NC-1:0] oh;
        oh = (ch >= 0) ? (NC'(1) << ch) : '0;
        i_avmm_read = rd; i_avmm_write = wr; i_port_sel = sel; i_port_swap_en = sw;
        i_avmm_addr = addr; i_avmm_writedata = wd;
        tick();
        i_avmm_read = 1'b0; i_avmm_write = 1'b0; i_port_sel = ~sel; i_port_swap_en = ~sw;
        i_avmm_addr = ~addr; i_avmm_writedata = ~wd;
        rc = -1; rc0 = -1; nstr = 0; nbad = 0; nlow = 0; rdo = '0; rdo0 = '0;
        for (int c = 1; c <= 60; c++) begin
            i_ch_waitrequest = (c <= stall) ? '1 : '0;
            if (|o_ch_read || |o_ch_write) begin
                nstr++;
                if (o_ch_read != (wr ? '0 : oh) || o_ch_write != (wr ? oh : '0) || o_ch_addr != addr ||
                    (wr && o_ch_writedata != wd)) nbad++;
            end
            if (!o_avmm_waitrequest) begin
                nlow++;
                if (rc < 0) begin rc = c; rdo = o_avmm_readdata; end
            end
            if (!wait0 && rc0 < 0) begin rc0 = c; rdo0 = rdata0; end
            tick();
        end
        i_ch_waitrequest = '0;
    endtask

    initial begin
        int rc, rc0, nstr, nbad, nlow;
        logic [DW-1:0] rdo, rdo0;
        for (int n = 0; n < NC; n++)
            i_ch_readdata[n*DW +: DW] = (n == 5) ? 32'h1234_5678 : {16'hC0DE, 8'(n), 8'h5A};
        //        rd    wr    sel     sw    stall ch  rdata          resp bad
        v[0] = '{1'b1, 1'b0, 6'd5,  1'b0, 0, 5,  32'h1234_5678, 5, 1'b0};
        v[1] = '{1'b0, 1'b1, 6'd2,  1'b1, 4, 3,  32'h1234_5678, 9, 1'b0};
        v[2] = '{1'b1, 1'b0, 6'd20, 1'b0, 0, -1, 32'hFFFF_FFFF, 4, 1'b1};
        v[3] = '{1'b1, 1'b0, 6'd10, 1'b1, 2, 11, 32'hC0DE_0B5A, 7, 1'b0};
        v[4] = '{1'b1, 1'b1, 6'd0,  1'b0, 0, 0,  32'hC0DE_0B5A, 5, 1'b0};
        v[5] = '{1'b1, 1'b0, 6'd15, 1'b1, 1, 14, 32'hC0DE_0E5A, 6, 1'b0};
        v[6] = '{1'b1, 1'b0, 6'd14, 1'b1, 0, 15, 32'hC0DE_0F5A, 5, 1'b0};
        v[7] = '{1'b0, 1'b1, 6'd63, 1'b0, 0, -1, 32'hFFFF_FFFF, 4, 1'b1};
        v[8] = '{1'b1, 1'b0, 6'd17, 1'b1, 0, -1, 32'hFFFF_FFFF, 4, 1'b1};
        v[9] = '{1'b1, 1'b0, 6'd1,  1'b0, 0, 1,  32'hC0DE_015A, 5, 1'b0};

        tick(); tick();
        chk("rst_waitreq", 32'(o_avmm_waitrequest), 32'd1);
        chk("rst_rdata", o_avmm_readdata, 32'd0);
        chk("rst_strobes", {o_ch_read, o_ch_write}, 32'd0);
        chk("rst_addr_wd", {16'd0, o_ch_addr} | o_ch_writedata, 32'd0);
        chk("rst_flags", {29'd0, o_err_badport, o_err_timeout, o_busy}, 32'd0);
        softreset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_txn(v[i].rd, v[i].wr, v[i].sel, v[i].sw, v[i].stall, v[i].ch, 16'(16'h0100 + i),
                    32'hD000_0000 + 32'(i), rc, rc0, nstr, nbad, nlow, rdo, rdo0);
            chk($sformatf("v%0d_resp_cycle", i), rc, v[i].resp);
            chk($sformatf("v%0d_resp_cycle_wp0", i), rc0, v[i].bad ? 1 : v[i].resp - 3);
            chk($sformatf("v%0d_readdata", i), rdo, v[i].rdata);
            chk($sformatf("v%0d_readdata_wp0", i), rdo0, v[i].rdata);
            chk($sformatf("v%0d_strobe_cycles", i), nstr, v[i].bad ? 0 : v[i].stall + 1);
            chk($sformatf("v%0d_strobe_wrong", i), nbad, 0);
            chk($sformatf("v%0d_resp_len", i), nlow, 1);
            chk($sformatf("v%0d_badport", i), 32'(o_err_badport), 32'(v[i].bad));
            chk($sformatf("v%0d_readdata_hold", i), o_avmm_readdata, v[i].rdata);
            i_err_clr = 1'b1; tick(); i_err_clr = 1'b0;
            chk($sformatf("v%0d_badport_clr", i), 32'(o_err_badport), 32'd0);
        end

        // bad-port set and error clear in the same cycle: set wins
        i_avmm_read = 1'b1; i_port_sel = 6'd20; i_port_swap_en = 1'b0; i_err_clr = 1'b1;
        tick();
        i_avmm_read = 1'b0; i_err_clr = 1'b0;
        chk("set_vs_clr", 32'(o_err_badport), 32'd1);
        for (int c = 0; c < 8; c++) tick();
        chk("badport_sticky", 32'(o_err_badport), 32'd1);
        i_err_clr = 1'b1; tick(); i_err_clr = 1'b0;
        chk("badport_cleared", 32'(o_err_badport), 32'd0);

        // softreset in the middle of ISSUE
        i_ch_waitrequest = '1;
        i_avmm_read = 1'b1; i_port_sel = 6'd4; i_avmm_addr = 16'h0ABC;
        tick();
        i_avmm_read = 1'b0;
        tick(); tick();
        chk("issue_before_rst", o_ch_read, 32'h0000_0010);
        softreset = 1'b1;
        #1;
        chk("rst_async_strobe", {o_ch_read, o_ch_write}, 32'd0);
        chk("rst_async_busy", {o_busy, o_avmm_waitrequest}, 32'd1);
        chk("rst_async_rdata", o_avmm_readdata, 32'd0);
        tick();
        softreset = 1'b0; i_ch_waitrequest = '0;
        tick();
        run_txn(1'b1, 1'b0, 6'd4, 1'b0, 0, 4, 16'h0044, 32'd0, rc, rc0, nstr, nbad, nlow, rdo, rdo0);
        chk("post_rst_resp", rc, 5);
        chk("post_rst_rdata", rdo, 32'hC0DE_045A);
        chk("post_rst_strobe", nstr, 1);
        chk("post_rst_wrong", nbad, 0);

        // downstream that never answers (timeout build) or answers after 40 stalls (default build)
`ifdef HE_HSSI_AVMM_TIMEOUT_EN
        run_txn(1'b1, 1'b0, 6'd0, 1'b0, 1000, 0, 16'h0055, 32'd0, rc, rc0, nstr, nbad, nlow, rdo, rdo0);
        chk("to_strobe_cycles", nstr, 16);
        chk("to_resp", rc, 20);
        chk("to_resp_wp0", rc0, 17);
        chk("to_rdata", rdo, 32'hFFFF_FFFF);
        chk("to_flag", 32'(o_err_timeout), 32'd1);
        i_err_clr = 1'b1; tick(); i_err_clr = 1'b0;
        chk("to_flag_clr", 32'(o_err_timeout), 32'd0);
`else
        run_txn(1'b1, 1'b0, 6'd0, 1'b0, 40, 0, 16'h0055, 32'd0, rc, rc0, nstr, nbad, nlow, rdo, rdo0);
        chk("long_stall_strobe_cycles", nstr, 41);
        chk("long_stall_resp", rc, 45);
        chk("long_stall_resp_wp0", rc0, 42);
        chk("long_stall_rdata", rdo, 32'hC0DE_005A);
        chk("no_timeout_flag", 32'(o_err_timeout), 32'd0);
`endif
        chk("wrong_strobe_final", nbad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
